pll_seq_ctrl: RTL and testbench

- Sequencer and dynamic-reconfiguration controller for the fft_pll instance.
- Runs the power-down, reset and lock-wait bring-up sequence, qualifies pll_lock, and retries on lock timeout.
- Accepts per-channel output-divider/duty/phase update requests over a valid/ready handshake, then re-locks the PLL after each accepted update.
- Sits between system control and the PLL dyn_* / pll_pwd / pll_rst pins.

---
 rtl/pll_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_pll_seq_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_seq_ctrl.sv
// pll_seq_ctrl: power-down / reset / lock-wait sequencer and dynamic divider/duty/phase controller for fft_pll.
// Defining PLL_SEQ_STATS_EN builds the lost_cnt / tmo_cnt statistics counters; otherwise those ports read 0.
module pll_seq_ctrl #(
  parameter int          PWD_CYCLES   = 10,
  parameter int          RST_CYCLES   = 10,
  parameter int          LOCK_TIMEOUT = 65535,
  parameter int          LOCK_FILT    = 4,
  parameter int          MAX_RETRY    = 3,
  parameter logic [9:0]  ODIV_RST     = 10'd100,
  parameter logic [9:0]  DUTY_RST     = 10'd100,
  parameter logic [12:0] PHASE_RST    = 13'd16
) (
  input  logic        clk_tb,
  input  logic        rst_n,
  input  logic        pll_lock,
  input  logic        restart,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_ch,
  input  logic [9:0]  cfg_odiv,
  input  logic [9:0]  cfg_duty,
  input  logic [12:0] cfg_phase,
  output logic        cfg_err,
  output logic        pll_pwd,
  output logic        pll_rst,
  output logic [49:0] dyn_odiv,
  output logic [49:0] dyn_duty,
  output logic [64:0] dyn_phase,
  output logic        locked,
  output logic        fail,
  output logic [2:0]  state_o,
  output logic [7:0]  lost_cnt,
  output logic [7:0]  tmo_cnt
);
  typedef enum logic [2:0] {
    S_PWD       = 3'd0,
    S_RST       = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_LOCKED    = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  localparam int FILT_W  = $clog2(LOCK_FILT + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  state_t             state, state_nxt;
  logic [15:0]        seq_cnt;
  logic [15:0]        tmo;
  logic [RETRY_W-1:0] retry;
  logic [FILT_W-1:0]  filt;
  logic               lock_meta, lock_s, lock_q;
  logic               accept, bad_req, timeout, enter_rst;

  // lock_q counts the current lock_s cycle, so lock is declared LOCK_FILT+2 edges after pll_lock rises
  assign lock_q    = lock_s && (filt >= FILT_W'(LOCK_FILT - 1));
  assign enter_rst = (state_nxt == S_RST) && (state != S_RST);

  assign cfg_ready = (state == S_LOCKED);
  assign locked    = (state == S_LOCKED);
  assign fail      = (state == S_FAIL);
  assign pll_pwd   = (state == S_PWD) || (state == S_FAIL);
  assign pll_rst   = (state == S_PWD) || (state == S_RST) || (state == S_FAIL);
  assign state_o   = state;

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) state <= S_PWD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    bad_req   = 1'b0;
    timeout   = 1'b0;
    if (restart) begin
      state_nxt = S_PWD;
    end else begin
      case (state)
        S_PWD:       if (seq_cnt == 16'(PWD_CYCLES - 1)) state_nxt = S_RST;
        S_RST:       if (seq_cnt == 16'(RST_CYCLES - 1)) state_nxt = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (lock_q) begin
            state_nxt = S_LOCKED;
          end else if (tmo == 16'(LOCK_TIMEOUT - 1)) begin
            timeout   = 1'b1;
            state_nxt = (int'(retry) + 1 < MAX_RETRY) ? S_PWD : S_FAIL;
          end
        end
        S_LOCKED: begin
          // lock loss outranks a same-cycle update request
          if (!lock_s) begin
            state_nxt = S_RST;
          end else if (cfg_valid) begin
            if (cfg_ch <= 3'd4) begin
              accept    = 1'b1;
              state_nxt = S_RST;
            end else begin
              bad_req   = 1'b1;
            end
          end
        end
        S_FAIL:      state_nxt = S_FAIL;
        default:     state_nxt = S_PWD;
      endcase
    end
  end

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      filt      <= '0;
      seq_cnt   <= '0;
      tmo       <= '0;
      retry     <= '0;
      cfg_err   <= 1'b0;
      dyn_odiv  <= {5{ODIV_RST}};
      dyn_duty  <= {5{DUTY_RST}};
      dyn_phase <= {5{PHASE_RST}};
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      if (enter_rst || !lock_s)                filt <= '0;
      else if (filt != FILT_W'(LOCK_FILT))     filt <= filt + 1'b1;
      if (restart || state_nxt != state)       seq_cnt <= '0;
      else if (state == S_PWD || state == S_RST) seq_cnt <= seq_cnt + 16'd1;
      tmo <= (state == S_WAIT_LOCK && state_nxt == S_WAIT_LOCK) ? tmo + 16'd1 : 16'd0;
      if (restart)                                 retry <= '0;
      else if (state == S_WAIT_LOCK && lock_q)     retry <= '0;
      else if (timeout)                            retry <= retry + 1'b1;
      cfg_err <= bad_req;
      for (int n = 0; n < 5; n++) begin
        if (accept && cfg_ch == 3'(n)) begin
          dyn_odiv[10*n +: 10]  <= cfg_odiv;
          dyn_duty[10*n +: 10]  <= cfg_duty;
          dyn_phase[13*n +: 13] <= cfg_phase;
        end
      end
    end
  end

`ifdef PLL_SEQ_STATS_EN
  logic lost_evt;
  assign lost_evt = (state == S_LOCKED) && !lock_s && !restart;

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      lost_cnt <= 8'd0;
      tmo_cnt  <= 8'd0;
    end else begin
      if (lost_evt && lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;
      if (timeout && tmo_cnt != 8'hFF)   tmo_cnt  <= tmo_cnt + 8'd1;
    end
  end
`else
  assign lost_cnt = 8'd0;
  assign tmo_cnt  = 8'd0;
`endif
endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Directed bench for pll_seq_ctrl: bring-up, reconfiguration, bad channel, lock glitches, timeout/fail, mid-run reset.
module tb_pll_seq_ctrl;
  logic        clk_tb = 1'b0;
  logic        rst_n = 1'b1;
  logic        pll_lock = 1'b0;
  logic        restart = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [2:0]  cfg_ch = 3'd0;
  logic [9:0]  cfg_odiv = 10'd0;
  logic [9:0]  cfg_duty = 10'd0;
  logic [12:0] cfg_phase = 13'd0;
  logic        cfg_ready, cfg_err, pll_pwd, pll_rst, locked, fail;
  logic [49:0] dyn_odiv, dyn_duty;
  logic [64:0] dyn_phase;
  logic [2:0]  state_o;
  logic [7:0]  lost_cnt, tmo_cnt;

`ifdef PLL_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  logic [49:0] m_odiv, m_duty;
  logic [64:0] m_phase;

  pll_seq_ctrl #(.LOCK_TIMEOUT(50)) dut (
    .clk_tb(clk_tb), .rst_n(rst_n), .pll_lock(pll_lock), .restart(restart),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_odiv(cfg_odiv),
    .cfg_duty(cfg_duty), .cfg_phase(cfg_phase), .cfg_err(cfg_err), .pll_pwd(pll_pwd),
    .pll_rst(pll_rst), .dyn_odiv(dyn_odiv), .dyn_duty(dyn_duty), .dyn_phase(dyn_phase),
    .locked(locked), .fail(fail), .state_o(state_o), .lost_cnt(lost_cnt), .tmo_cnt(tmo_cnt)
  );

  always #5 clk_tb = ~clk_tb;

  task automatic tick();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic model_reset();
    m_odiv  = {5{10'd100}};
    m_duty  = {5{10'd100}};
    m_phase = {5{13'd16}};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    model_reset();
    total++; if (state_o !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state_o); end
    total++; if ({pll_pwd, pll_rst, locked, fail, cfg_ready, cfg_err} !== 6'b110000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 110000", {pll_pwd, pll_rst, locked, fail, cfg_ready, cfg_err}); end
    total++; if ({dyn_odiv, dyn_duty, dyn_phase} !== {m_odiv, m_duty, m_phase}) begin
      bad++; $display("FAIL reset_dyn: got %h want %h", {dyn_odiv, dyn_duty, dyn_phase}, {m_odiv, m_duty, m_phase}); end
    total++; if ({lost_cnt, tmo_cnt} !== 16'd0) begin bad++; $display("FAIL reset_stats: got %h want 0", {lost_cnt, tmo_cnt}); end
    @(posedge clk_tb); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_bringup();
    int n;
    n = 0;
    while (pll_pwd && n < 100) begin tick(); n++; end
    total++; if (n !== 10) begin bad++; $display("FAIL pwd_len: got %0d want 10", n); end
    total++; if (state_o !== 3'd1 || pll_rst !== 1'b1) begin bad++; $display("FAIL enter_rst: got state %0d rst %b want 1 1", state_o, pll_rst); end
    n = 0;
    while (pll_rst && n < 100) begin tick(); n++; end
    total++; if (n !== 10) begin bad++; $display("FAIL rst_len: got %0d want 10", n); end
    repeat (30) tick();
    total++; if (state_o !== 3'd2 || locked !== 1'b0) begin bad++; $display("FAIL wait_lock: got state %0d locked %b want 2 0", state_o, locked); end
    pll_lock = 1'b1;
    n = 0;
    while (!locked && n < 100) begin tick(); n++; end
    total++; if (n !== 6) begin bad++; $display("FAIL lock_latency: got %0d want 6", n); end
    total++; if (state_o !== 3'd3 || cfg_ready !== 1'b1) begin bad++; $display("FAIL locked_state: got %0d ready %b want 3 1", state_o, cfg_ready); end
  endtask

  task automatic test_reconfig();
    int n;
    cfg_ch = 3'd2; cfg_odiv = 10'd200; cfg_duty = 10'd200; cfg_phase = 13'd8; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    m_odiv[29:20] = 10'd200; m_duty[29:20] = 10'd200; m_phase[38:26] = 13'd8;
    total++; if (dyn_odiv[29:20] !== 10'd200) begin bad++; $display("FAIL cfg_odiv_ch2: got %0d want 200", dyn_odiv[29:20]); end
    total++; if ({dyn_odiv, dyn_duty, dyn_phase} !== {m_odiv, m_duty, m_phase}) begin
      bad++; $display("FAIL cfg_dyn: got %h want %h", {dyn_odiv, dyn_duty, dyn_phase}, {m_odiv, m_duty, m_phase}); end
    total++; if (state_o !== 3'd1 || pll_rst !== 1'b1 || locked !== 1'b0) begin
      bad++; $display("FAIL cfg_relock_start: got state %0d rst %b locked %b want 1 1 0", state_o, pll_rst, locked); end
    n = 0;
    while (pll_rst && n < 100) begin tick(); n++; end
    total++; if (n !== 10) begin bad++; $display("FAIL cfg_rst_len: got %0d want 10", n); end
    n = 0;
    while (!locked && n < 100) begin tick(); n++; end
    total++; if (n < 1 || n > 6) begin bad++; $display("FAIL cfg_relock: got %0d cycles want 1..6", n); end
  endtask

  task automatic test_bad_channel();
    cfg_ch = 3'd6; cfg_odiv = 10'd555; cfg_duty = 10'd444; cfg_phase = 13'd333; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL bad_ch_err: got %b want 1", cfg_err); end
    total++; if (state_o !== 3'd3) begin bad++; $display("FAIL bad_ch_state: got %0d want 3", state_o); end
    total++; if ({dyn_odiv, dyn_duty, dyn_phase} !== {m_odiv, m_duty, m_phase}) begin
      bad++; $display("FAIL bad_ch_dyn: got %h want %h", {dyn_odiv, dyn_duty, dyn_phase}, {m_odiv, m_duty, m_phase}); end
    tick();
    total++; if (cfg_err !== 1'b0 || state_o !== 3'd3) begin bad++; $display("FAIL bad_ch_pulse: got err %b state %0d want 0 3", cfg_err, state_o); end
  endtask

  task automatic test_lock_glitch(input bit with_cfg, input logic [7:0] exp_lost);
    int n;
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    tick();
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL glitch_pre: got locked %b want 1", locked); end
    if (with_cfg) begin
      cfg_ch = 3'd1; cfg_odiv = 10'd7; cfg_duty = 10'd9; cfg_phase = 13'd11; cfg_valid = 1'b1;
    end
    tick();
    cfg_valid = 1'b0;
    total++; if (state_o !== 3'd1 || locked !== 1'b0) begin bad++; $display("FAIL glitch_rst: got state %0d locked %b want 1 0", state_o, locked); end
    total++; if ({dyn_odiv, dyn_duty, dyn_phase} !== {m_odiv, m_duty, m_phase}) begin
      bad++; $display("FAIL glitch_dyn: got %h want %h", {dyn_odiv, dyn_duty, dyn_phase}, {m_odiv, m_duty, m_phase}); end
    total++; if (lost_cnt !== exp_lost) begin bad++; $display("FAIL lost_cnt: got %0d want %0d", lost_cnt, exp_lost); end
    n = 0;
    while (!locked && n < 100) begin tick(); n++; end
    total++; if (n !== 11) begin bad++; $display("FAIL glitch_relock: got %0d want 11", n); end
  endtask

  task automatic test_timeout_fail();
    int n;
    int rounds;
    logic [2:0] prev;
    pll_lock = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    total++; if (state_o !== 3'd0) begin bad++; $display("FAIL restart_pwd: got %0d want 0", state_o); end
    n = 0; rounds = 0; prev = state_o;
    while (!fail && n < 1000) begin
      tick(); n++;
      if (prev == 3'd0 && state_o == 3'd1) rounds++;
      prev = state_o;
    end
    total++; if (n !== 210) begin bad++; $display("FAIL fail_time: got %0d want 210", n); end
    total++; if (rounds !== 3) begin bad++; $display("FAIL fail_rounds: got %0d want 3", rounds); end
    repeat (5) tick();
    total++; if ({state_o, fail, pll_pwd, pll_rst, locked, cfg_ready} !== {3'd4, 5'b11100}) begin
      bad++; $display("FAIL fail_state: got %0d %b want 4 11100", state_o, {fail, pll_pwd, pll_rst, locked, cfg_ready}); end
    total++; if (tmo_cnt !== (STATS ? 8'd3 : 8'd0)) begin bad++; $display("FAIL tmo_cnt: got %0d want %0d", tmo_cnt, STATS ? 3 : 0); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    total++; if (state_o !== 3'd0 || fail !== 1'b0 || pll_pwd !== 1'b1) begin
      bad++; $display("FAIL fail_restart: got state %0d fail %b pwd %b want 0 0 1", state_o, fail, pll_pwd); end
    total++; if ({dyn_odiv, dyn_duty, dyn_phase} !== {m_odiv, m_duty, m_phase}) begin
      bad++; $display("FAIL restart_keeps_dyn: got %h want %h", {dyn_odiv, dyn_duty, dyn_phase}, {m_odiv, m_duty, m_phase}); end
  endtask

  task automatic test_mid_reset();
    int n;
    pll_lock = 1'b1;
    n = 0;
    while (!locked && n < 100) begin tick(); n++; end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL mid_lock: got %b want 1", locked); end
    cfg_ch = 3'd4; cfg_odiv = 10'd1; cfg_duty = 10'd2; cfg_phase = 13'd8191; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    pll_lock = 1'b0;
    total++; if (dyn_phase[64:52] !== 13'd8191 || dyn_odiv[49:40] !== 10'd1 || dyn_duty[49:40] !== 10'd2) begin
      bad++; $display("FAIL cfg_ch4: got %0d %0d %0d want 1 2 8191", dyn_odiv[49:40], dyn_duty[49:40], dyn_phase[64:52]); end
    n = 0;
    while (state_o != 3'd2 && n < 100) begin tick(); n++; end
    repeat (3) tick();
    rst_n = 1'b0;
    #2;
    model_reset();
    total++; if ({dyn_odiv, dyn_duty, dyn_phase} !== {m_odiv, m_duty, m_phase}) begin
      bad++; $display("FAIL mid_reset_dyn: got %h want %h", {dyn_odiv, dyn_duty, dyn_phase}, {m_odiv, m_duty, m_phase}); end
    total++; if (state_o !== 3'd0 || pll_pwd !== 1'b1 || pll_rst !== 1'b1) begin
      bad++; $display("FAIL mid_reset_ctrl: got state %0d pwd %b rst %b want 0 1 1", state_o, pll_pwd, pll_rst); end
    total++; if ({lost_cnt, tmo_cnt} !== 16'd0) begin bad++; $display("FAIL mid_reset_stats: got %h want 0", {lost_cnt, tmo_cnt}); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    test_reset();
    test_bringup();
    test_reconfig();
    test_bad_channel();
    test_lock_glitch(1'b0, STATS ? 8'd1 : 8'd0);
    test_lock_glitch(1'b1, STATS ? 8'd2 : 8'd0);
    test_timeout_fail();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
